// File: rtl/dmem_banked.sv
// dmem_banked: single-port word memory with per-byte-lane write strobes and an RD_LAT-deep
// read-first response pipeline. Define DMEM_ZERO_INIT_EN to zero every word after reset.
module dmem_banked #(
    parameter int DEPTH  = 4096,
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [DW/8-1:0] req_we,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err
);
    // state | meaning
    // CLEAR | zeroing one word per cycle, requests held off
    // READY | accepting one request per cycle until reset
    localparam int NL = DW / 8;
    localparam int LB = $clog2(NL);
    localparam int IW = AW - LB;
    localparam int DA = $clog2(DEPTH);

    typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

`ifdef DMEM_ZERO_INIT_EN
    localparam state_t RST_STATE = CLEAR;
`else
    localparam state_t RST_STATE = READY;
`endif

    state_t        state, state_nx;
    logic [DW-1:0] mem [DEPTH];
    logic [IW-1:0] idx;
    logic [DA-1:0] waddr;
    logic          in_range;
    logic          accept;
    logic          clr_we;
    logic          clr_done;

    logic          pipe_valid [RD_LAT];
    logic          pipe_err   [RD_LAT];
    logic [DW-1:0] pipe_data  [RD_LAT];

    assign idx    = req_addr[AW-1:LB];
    assign waddr  = idx[DA-1:0];
    assign accept = req_valid && req_ready;

    generate
        if (IW > DA) begin : g_range
            assign in_range = (idx[IW-1:DA] == '0);
        end else begin : g_full
            assign in_range = 1'b1;
        end
        if (LB > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^req_addr[LB-1:0];
        end
    endgenerate

`ifdef DMEM_ZERO_INIT_EN
    logic [DA-1:0] clr_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_idx <= '0;
        end else if (clr_we) begin
            clr_idx <= clr_idx + DA'(1);
        end
    end

    assign clr_done = (clr_idx == DA'(DEPTH - 1));
`else
    assign clr_done = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RST_STATE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            CLEAR: if (clr_done) state_nx = READY;
            READY: state_nx = READY;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        clr_we    = 1'b0;
        case (state)
            CLEAR: clr_we    = !reset;
            READY: req_ready = !reset;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
`ifdef DMEM_ZERO_INIT_EN
            mem[clr_idx] <= '0;
`endif
        end else if (accept && in_range) begin
            for (int k = 0; k < NL; k++) begin
                if (req_we[k]) begin
                    mem[waddr][8*k +: 8] <= req_wdata[8*k +: 8];
                end
            end
        end
    end

    // Stage 0 samples the word before this edge's write lands, giving read-first data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_err[i]   <= 1'b0;
                pipe_data[i]  <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && !in_range;
            pipe_data[0]  <= (accept && in_range) ? mem[waddr] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    always_comb begin
        rsp_valid = pipe_valid[RD_LAT-1] && !reset;
        rsp_err   = rsp_valid && pipe_err[RD_LAT-1];
        rsp_rdata = rsp_valid ? pipe_data[RD_LAT-1] : '0;
    end

endmodule

// File: tb/tb_dmem_banked.sv
// Self-checking bench for dmem_banked: word-array and response-queue reference model,
// directed scenarios plus randomized traffic. Valid with or without DMEM_ZERO_INIT_EN.
module tb_dmem_banked;
    localparam int DEPTH  = 64;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int RD_LAT = 3;
    localparam int NL     = DW / 8;
`ifdef DMEM_ZERO_INIT_EN
    localparam bit ZINIT = 1'b1;
`else
    localparam bit ZINIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [NL-1:0] req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    dmem_banked #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct { int due; bit err; bit kn; logic [DW-1:0] data; } rsp_t;
    typedef struct { bit rst; bit v; logic [NL-1:0] we; logic [AW-1:0] a; logic [DW-1:0] d; } stim_t;

    // Reference model: memory words, which words hold known data, responses owed by edge number.
    rsp_t          pend [$];
    logic [DW-1:0] mdl [DEPTH];
    bit            known [DEPTH];
    int            clr_left = 0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    bit            er, ev, ee, ek;
    logic [DW-1:0] ed;

    task automatic expect_now();
        er = !reset && clr_left == 0;
        ev = 1'b0; ee = 1'b0; ek = 1'b1; ed = '0;
        if (!reset && pend.size() > 0) begin
            if (pend[0].due == cyc) begin
                ev = 1'b1; ee = pend[0].err; ek = pend[0].kn; ed = pend[0].data;
            end
        end
    endtask

    task automatic drive(input stim_t s);
        reset = s.rst; req_valid = s.v; req_we = s.we; req_addr = s.a; req_wdata = s.d;
        #1;
    endtask

    task automatic tick();
        bit            acc;
        logic [AW-1:0] widx;
        int            i;
        acc  = req_valid && !reset && clr_left == 0;
        widx = req_addr >> $clog2(NL);
        if (pend.size() > 0) begin
            if (pend[0].due == cyc) void'(pend.pop_front());
        end
        @(posedge clk);
        cyc++;
        if (reset) begin
            pend.delete();
            clr_left = ZINIT ? DEPTH : 0;
        end else if (clr_left > 0) begin
            mdl[DEPTH - clr_left]   = '0;
            known[DEPTH - clr_left] = 1'b1;
            clr_left--;
        end else if (acc) begin
            if (widx >= AW'(DEPTH)) begin
                pend.push_back('{due: cyc + RD_LAT - 1, err: 1'b1, kn: 1'b1, data: '0});
            end else begin
                i = int'(widx);
                pend.push_back('{due: cyc + RD_LAT - 1, err: 1'b0, kn: known[i], data: mdl[i]});
                for (int k = 0; k < NL; k++) if (req_we[k]) mdl[i][8*k +: 8] = req_wdata[8*k +: 8];
                if (&req_we) known[i] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        stim_t s;
        for (int i = 0; i < 3 + DEPTH + 4; i++) begin
            s = '{(i < 3), 1'b0, '0, '0, '0};
            drive(s);
            expect_now();
            n_cmp++;
            if (req_ready !== er || rsp_valid !== ev || rsp_err !== ee || rsp_rdata !== ed) begin
                n_bad++;
                $display("FAIL reset cyc=%0d ready=%b want %b valid=%b want %b err=%b want %b rdata=%h want %h",
                         cyc, req_ready, er, rsp_valid, ev, rsp_err, ee, rsp_rdata, ed);
            end
            tick();
        end
    endtask

    task automatic test_preload();
        stim_t s;
        for (int i = 0; i < DEPTH + RD_LAT + 1; i++) begin
            s = '{1'b0, (i < DEPTH), '1, AW'(4 * i), DW'($urandom)};
            drive(s);
            expect_now();
            n_cmp++;
            if (req_ready !== er || rsp_valid !== ev || rsp_err !== ee || (ek && rsp_rdata !== ed)) begin
                n_bad++;
                $display("FAIL preload cyc=%0d ready=%b want %b valid=%b want %b err=%b want %b rdata=%h want %h",
                         cyc, req_ready, er, rsp_valid, ev, rsp_err, ee, rsp_rdata, ed);
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        stim_t         s [$];
        logic [DW-1:0] got [$];
        s.push_back('{1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF});
        s.push_back('{1'b0, 1'b1, 4'h0, 32'h10, 32'h0});
        s.push_back('{1'b0, 1'b1, 4'h1, 32'h10, 32'h000000AA});
        s.push_back('{1'b0, 1'b1, 4'h0, 32'h10, 32'h0});
        for (int i = 0; i < RD_LAT + 1; i++) s.push_back('{1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
        foreach (s[i]) begin
            drive(s[i]);
            expect_now();
            if (rsp_valid) got.push_back(rsp_rdata);
            n_cmp++;
            if (req_ready !== er || rsp_valid !== ev || rsp_err !== ee || (ek && rsp_rdata !== ed)) begin
                n_bad++;
                $display("FAIL wr_rd cyc=%0d ready=%b want %b valid=%b want %b err=%b want %b rdata=%h want %h",
                         cyc, req_ready, er, rsp_valid, ev, rsp_err, ee, rsp_rdata, ed);
            end
            tick();
        end
        n_cmp++;
        if (got.size() != 4) begin
            n_bad++;
            $display("FAIL wr_rd_count responses=%0d want 4", got.size());
        end else if (got[1] !== 32'hDEADBEEF || got[2] !== 32'hDEADBEEF || got[3] !== 32'hDEADBEAA) begin
            n_bad++;
            $display("FAIL wr_rd_data got %h %h %h want deadbeef deadbeef deadbeaa", got[1], got[2], got[3]);
        end
    endtask

    task automatic test_out_of_range();
        stim_t         s [$];
        bit            gerr [$];
        logic [DW-1:0] gdat [$];
        s.push_back('{1'b0, 1'b1, 4'h0, AW'(4 * DEPTH), 32'h0});
        s.push_back('{1'b0, 1'b1, 4'hF, AW'(4 * DEPTH), 32'h12345678});
        s.push_back('{1'b0, 1'b1, 4'h0, 32'h0, 32'h0});
        s.push_back('{1'b0, 1'b1, 4'h0, 32'hFFFF_FFFC, 32'h0});
        s.push_back('{1'b0, 1'b1, 4'h0, 32'h3, 32'h0});
        for (int i = 0; i < RD_LAT + 1; i++) s.push_back('{1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
        foreach (s[i]) begin
            drive(s[i]);
            expect_now();
            if (rsp_valid) begin gerr.push_back(rsp_err); gdat.push_back(rsp_rdata); end
            n_cmp++;
            if (req_ready !== er || rsp_valid !== ev || rsp_err !== ee || (ek && rsp_rdata !== ed)) begin
                n_bad++;
                $display("FAIL oor cyc=%0d ready=%b want %b valid=%b want %b err=%b want %b rdata=%h want %h",
                         cyc, req_ready, er, rsp_valid, ev, rsp_err, ee, rsp_rdata, ed);
            end
            tick();
        end
        n_cmp++;
        if (gerr.size() != 5) begin
            n_bad++;
            $display("FAIL oor_count responses=%0d want 5", gerr.size());
        end else if ({gerr[0], gerr[1], gerr[2], gerr[3], gerr[4]} !== 5'b11010 ||
                     gdat[0] !== '0 || gdat[1] !== '0 || gdat[3] !== '0 || gdat[2] !== gdat[4]) begin
            n_bad++;
            $display("FAIL oor_pattern err=%b%b%b%b%b want 11010 data=%h %h %h %h %h",
                     gerr[0], gerr[1], gerr[2], gerr[3], gerr[4], gdat[0], gdat[1], gdat[2], gdat[3], gdat[4]);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s [$];
        int    when [$];
        int    start;
        s.push_back('{1'b0, 1'b1, 4'h0, 32'h0, 32'h0});
        s.push_back('{1'b0, 1'b1, 4'h0, 32'h4, 32'h0});
        s.push_back('{1'b0, 1'b1, 4'h0, 32'h8, 32'h0});
        for (int i = 0; i < RD_LAT + 2; i++) s.push_back('{1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
        start = cyc;
        foreach (s[i]) begin
            drive(s[i]);
            expect_now();
            if (rsp_valid) when.push_back(cyc);
            n_cmp++;
            if (req_ready !== er || rsp_valid !== ev || rsp_err !== ee || (ek && rsp_rdata !== ed)) begin
                n_bad++;
                $display("FAIL b2b cyc=%0d ready=%b want %b valid=%b want %b err=%b want %b rdata=%h want %h",
                         cyc, req_ready, er, rsp_valid, ev, rsp_err, ee, rsp_rdata, ed);
            end
            tick();
        end
        n_cmp++;
        if (when.size() != 3) begin
            n_bad++;
            $display("FAIL b2b_count pulses=%0d want 3", when.size());
        end else if (when[0] != start + RD_LAT || when[1] != start + RD_LAT + 1 || when[2] != start + RD_LAT + 2) begin
            n_bad++;
            $display("FAIL b2b_timing pulses at +%0d +%0d +%0d want +%0d +%0d +%0d", when[0] - start,
                     when[1] - start, when[2] - start, RD_LAT, RD_LAT + 1, RD_LAT + 2);
        end
    endtask

    task automatic test_reset_flush();
        stim_t s [$];
        int    pulses = 0;
        s.push_back('{1'b0, 1'b1, 4'h0, 32'h0, 32'h0});
        s.push_back('{1'b0, 1'b1, 4'h0, 32'h4, 32'h0});
        s.push_back('{1'b1, 1'b1, 4'h0, 32'h8, 32'h0});
        for (int i = 0; i < int'(ZINIT) * DEPTH + RD_LAT + 2; i++) s.push_back('{1'b0, 1'b0, 4'h0, 32'h0, 32'h0});
        foreach (s[i]) begin
            drive(s[i]);
            expect_now();
            if (i >= 2 && rsp_valid) pulses++;
            n_cmp++;
            if (req_ready !== er || rsp_valid !== ev || rsp_err !== ee || (ek && rsp_rdata !== ed)) begin
                n_bad++;
                $display("FAIL flush cyc=%0d ready=%b want %b valid=%b want %b err=%b want %b rdata=%h want %h",
                         cyc, req_ready, er, rsp_valid, ev, rsp_err, ee, rsp_rdata, ed);
            end
            tick();
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL flush_pulses got %0d want 0", pulses);
        end
    endtask

    task automatic test_read_all();
        stim_t s;
        for (int i = 0; i < DEPTH + RD_LAT + 1; i++) begin
            s = '{1'b0, (i < DEPTH), '0, AW'(4 * i + $urandom_range(0, 3)), '0};
            drive(s);
            expect_now();
            n_cmp++;
            if (req_ready !== er || rsp_valid !== ev || rsp_err !== ee || (ek && rsp_rdata !== ed)) begin
                n_bad++;
                $display("FAIL read_all cyc=%0d ready=%b want %b valid=%b want %b err=%b want %b rdata=%h want %h",
                         cyc, req_ready, er, rsp_valid, ev, rsp_err, ee, rsp_rdata, ed);
            end
            tick();
        end
    endtask

    task automatic test_random();
        stim_t s;
        int    sel;
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 15);
            s.rst = (i < 560) && ($urandom_range(0, 99) == 0);
            s.v   = (i < 560) && ($urandom_range(0, 3) != 0);
            s.we  = ($urandom_range(0, 1) != 0) ? NL'($urandom) : '0;
            s.d   = DW'($urandom);
            s.a   = (sel == 0) ? AW'($urandom) :
                    (sel == 1) ? AW'(4 * DEPTH + $urandom_range(0, 63)) :
                                 AW'($urandom_range(0, 4 * DEPTH - 1));
            drive(s);
            expect_now();
            n_cmp++;
            if (req_ready !== er || rsp_valid !== ev || rsp_err !== ee || (ek && rsp_rdata !== ed)) begin
                n_bad++;
                $display("FAIL random cyc=%0d ready=%b want %b valid=%b want %b err=%b want %b rdata=%h want %h",
                         cyc, req_ready, er, rsp_valid, ev, rsp_err, ee, rsp_rdata, ed);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = '0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_preload();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_reset_flush();
        test_read_all();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
